mastermind_scorer: RTL and testbench
====================================

// Module: mastermind_scorer
// PURPOSE
//  Multi-cycle Mastermind feedback engine downstream of mastermind_core.
//  Latches a 4-peg guess and the secret answer on start (driven by q_Check),
//  then counts exact matches (right colour, right slot) and partial matches
//  (right colour, wrong slot). Results feed the win/lose decision and the VGA
//  feedback-peg renderer; held stable until the next accepted start.
// PARAMETERS
//  N_POS     4  pegs per guess; peg p occupies bits [p*COLOR_W +: COLOR_W]
//  COLOR_W   3  bits per peg colour code
//  N_COLORS  7  colour codes 0..N_COLORS-1; code 0 = blank (no colour)
// PORTS
//  Clk      in   1                  system clock, rising edge
//  Reset    in   1                  asynchronous, active-high reset
//  start    in   1                  request to score; sampled only when busy=0
//  guess    in   N_POS*COLOR_W      guess pegs, valid on the start cycle
//  answer   in   N_POS*COLOR_W      secret pegs, valid on the start cycle
//  busy     out  1                  scoring in progress
//  done     out  1                  one-cycle pulse: results valid
//  exact    out  CNT_W              exact-match count, CNT_W=$clog2(N_POS+1)
//  partial  out  CNT_W              partial-match count
//  win      out  1                  exact == N_POS
// BEHAVIOUR
//  - Reset (async): state IDLE; busy, done, exact, partial, win = 0;
//    pos index, colour index and all histogram counters = 0.
//  - States: IDLE -> EXACT -> COUNT -> DONE -> IDLE.
//  - IDLE: start=1 at edge k registers guess/answer, clears exact,
//    partial and both histograms, sets busy, enters EXACT (pos=0).
//  - EXACT: one peg per cycle, pos 0..N_POS-1. If g[pos]==a[pos] and
//    g[pos] is a valid non-blank code (1..N_COLORS-1), exact++. Otherwise
//    hist_g[g[pos]]++ and hist_a[a[pos]]++, skipping blank and out-of-range
//    codes. After pos N_POS-1, go to COUNT (c=1).
//  - COUNT: one colour per cycle, c=1..N_COLORS-1:
//    partial += min(hist_g[c], hist_a[c]). After c=N_COLORS-1, go to DONE.
//  - DONE: lasts one cycle. exact, partial and win update on the edge
//    entering DONE. done=1 and busy=0 for that cycle; then return to IDLE.
//  - Latency: done rises N_POS+N_COLORS-1 edges after edge k (10 with
//    defaults). busy is high from edge k until the edge done rises.
//  - Intermediate counts are held internally. The exact/partial/win ports
//    change only on the edge entering DONE (or on Reset).
//  - start while busy=1 is ignored, with no queueing. start during the DONE
//    cycle is accepted exactly as in IDLE (back-to-back scoring).
//  - Widths: exact+partial <= N_POS always; no counter wraps.
//    Histogram counters are CNT_W bits wide.
//  - Reset mid-operation aborts immediately: no done pulse, outputs zeroed.
//    The next start after Reset deasserts is scored normally.
// TESTING
//  1. answer=guess=12'b100_011_010_001, start -> done at edge k+10;
//     exact=4, partial=0, win=1.
//  2. answer=100_011_010_001, guess=001_010_011_100 -> exact=0, partial=4,
//     win=0.
//  3. Duplicate colours: answer=001_001_010_010, guess=001_010_001_011
//     -> exact=1, partial=2.
//  4. Blanks: guess=answer=000_000_000_000 -> exact=0, partial=0, win=0.
//     Also guess=111_111_111_111 -> exact=0, partial=0.
//  5. start pulsed again at k+3 with different data -> ignored; results
//     match the first data. Then Reset at k+5 -> all outputs 0, no done.
//  6. start held during the DONE cycle with new data -> busy re-asserts
//     next edge; a second done 10 edges later shows the new results.

Source files
------------

// File: rtl/mastermind_scorer.sv
// -----------------------------------------------------------------------------
// mastermind_scorer
//
// Purpose:
//   Multi-cycle Mastermind feedback engine. On an accepted start it latches a
//   guess and the secret answer. It then walks the peg slots one per cycle,
//   counting exact matches and building colour histograms of the unmatched
//   pegs. Next it walks the colour codes one per cycle, summing
//   min(hist_guess, hist_answer) into the partial-match count. The results are
//   published together with a one-cycle done pulse and are held until the next
//   result is published.
//
// Timing (default parameters):
//   start accepted at edge k -> done rises at edge k + N_POS + N_COLORS - 1.
//   busy is high from edge k until the edge on which done rises. A start during
//   the done cycle is accepted exactly as in idle, so scoring can run
//   back-to-back.
//
// Ports:
//   Clk      in   1                  system clock, rising edge
//   Reset    in   1                  asynchronous, active-high reset
//   start    in   1                  request to score; sampled only when busy=0
//   guess    in   N_POS*COLOR_W      guess pegs (peg p at [p*COLOR_W +: COLOR_W])
//   answer   in   N_POS*COLOR_W      secret pegs, same layout as guess
//   busy     out  1                  scoring in progress
//   done     out  1                  one-cycle pulse: results valid
//   exact    out  CNT_W              right colour, right slot
//   partial  out  CNT_W              right colour, wrong slot
//   win      out  1                  exact == N_POS
//
// Colour code 0 is blank. Codes >= N_COLORS are out of range. Neither kind
// ever scores.
// -----------------------------------------------------------------------------
module mastermind_scorer #(
  parameter int N_POS    = 4,
  parameter int COLOR_W  = 3,
  parameter int N_COLORS = 7,
  localparam int CNT_W   = $clog2(N_POS + 1)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [N_POS*COLOR_W-1:0] guess,
  input  logic [N_POS*COLOR_W-1:0] answer,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         exact,
  output logic [CNT_W-1:0]         partial,
  output logic                     win
);

  localparam int POS_W = (N_POS > 1) ? $clog2(N_POS) : 1;
  localparam int COL_W = $clog2(N_COLORS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXACT,
    S_COUNT,
    S_DONE
  } state_t;

  state_t                     r_state;
  logic [N_POS*COLOR_W-1:0]   r_guess;
  logic [N_POS*COLOR_W-1:0]   r_answer;
  logic [POS_W-1:0]           r_pos;
  logic [COL_W-1:0]           r_col;
  logic [CNT_W-1:0]           r_exact_cnt;
  logic [CNT_W-1:0]           r_partial_cnt;
  logic [CNT_W-1:0]           r_hist_g [N_COLORS];
  logic [CNT_W-1:0]           r_hist_a [N_COLORS];

  logic [COLOR_W-1:0]         w_g_peg;
  logic [COLOR_W-1:0]         w_a_peg;
  logic                       w_g_valid;
  logic                       w_a_valid;
  logic                       w_is_exact;
  logic [CNT_W-1:0]           w_hist_g_sel;
  logic [CNT_W-1:0]           w_hist_a_sel;
  logic [CNT_W-1:0]           w_min;
  logic [CNT_W-1:0]           w_partial_next;
  logic                       w_accept;
  logic                       w_last_pos;
  logic                       w_last_col;

  // Current peg pair and the histogram entries for the current colour.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_g_peg      = '0;
    w_a_peg      = '0;
    w_hist_g_sel = '0;
    w_hist_a_sel = '0;
    for (int p = 0; p < N_POS; p++) begin
      if (r_pos == POS_W'(p)) begin
        w_g_peg = r_guess[p*COLOR_W +: COLOR_W];
        w_a_peg = r_answer[p*COLOR_W +: COLOR_W];
      end
    end
    for (int c = 0; c < N_COLORS; c++) begin
      if (r_col == COL_W'(c)) begin
        w_hist_g_sel = r_hist_g[c];
        w_hist_a_sel = r_hist_a[c];
      end
    end
  end

  // Compare one bit wider so that N_COLORS == 2**COLOR_W still works.
  assign w_g_valid      = (w_g_peg != '0) &&
                          ({1'b0, w_g_peg} < (COLOR_W+1)'(N_COLORS));
  assign w_a_valid      = (w_a_peg != '0) &&
                          ({1'b0, w_a_peg} < (COLOR_W+1)'(N_COLORS));
  assign w_is_exact     = (w_g_peg == w_a_peg) && w_g_valid;
  assign w_min          = (w_hist_g_sel < w_hist_a_sel) ? w_hist_g_sel : w_hist_a_sel;
  assign w_partial_next = r_partial_cnt + w_min;
  assign w_last_pos     = (r_pos == POS_W'(N_POS - 1));
  assign w_last_col     = (r_col == COL_W'(N_COLORS - 1));
  // busy is low only in IDLE and DONE, so this is "start while not busy".
  assign w_accept       = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and simulation order cannot matter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_guess       <= '0;
      r_answer      <= '0;
      r_pos         <= '0;
      r_col         <= '0;
      r_exact_cnt   <= '0;
      r_partial_cnt <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      exact         <= '0;
      partial       <= '0;
      win           <= 1'b0;
      // NOTE: the histograms are small register arrays, not RAM. They are
      // reset explicitly because an aborted run must not leak counts.
      for (int c = 0; c < N_COLORS; c++) begin
        r_hist_g[c] <= '0;
        r_hist_a[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state       <= S_EXACT;
            r_guess       <= guess;
            r_answer      <= answer;
            r_pos         <= '0;
            r_col         <= '0;
            r_exact_cnt   <= '0;
            r_partial_cnt <= '0;
            busy          <= 1'b1;
            for (int c = 0; c < N_COLORS; c++) begin
              r_hist_g[c] <= '0;
              r_hist_a[c] <= '0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_EXACT: begin
          if (w_is_exact) begin
            r_exact_cnt <= r_exact_cnt + 1'b1;
          end else begin
            // Only unmatched pegs can contribute to partial matches. Blank and
            // out-of-range codes never match any colour slot.
            for (int c = 1; c < N_COLORS; c++) begin
              if (w_g_valid && (w_g_peg == COLOR_W'(c)))
                r_hist_g[c] <= r_hist_g[c] + 1'b1;
              if (w_a_valid && (w_a_peg == COLOR_W'(c)))
                r_hist_a[c] <= r_hist_a[c] + 1'b1;
            end
          end
          if (w_last_pos) begin
            r_state <= S_COUNT;
            r_col   <= COL_W'(1);
          end else begin
            r_pos <= r_pos + 1'b1;
          end
        end

        S_COUNT: begin
          r_partial_cnt <= w_partial_next;
          if (w_last_col) begin
            // Publish all results together on the edge that enters DONE.
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            exact   <= r_exact_cnt;
            partial <= w_partial_next;
            win     <= (r_exact_cnt == CNT_W'(N_POS));
          end else begin
            r_col <= r_col + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_scorer.sv
// -----------------------------------------------------------------------------
// tb_mastermind_scorer
//
// Scoreboarded bench for mastermind_scorer. Each accepted start pushes its
// expected score into a queue. Each done pulse pops the oldest entry and
// compares it with the published results. Fixed vectors carry hand-derived
// scores. Random vectors are scored by a small behavioural reference.
// -----------------------------------------------------------------------------
module tb_mastermind_scorer;

  localparam int N_POS    = 4;
  localparam int COLOR_W  = 3;
  localparam int N_COLORS = 7;
  localparam int CNT_W    = 3;
  localparam int W        = N_POS * COLOR_W;
  localparam int LAT      = N_POS + N_COLORS - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             start;
  logic [W-1:0]     guess;
  logic [W-1:0]     answer;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] exact;
  logic [CNT_W-1:0] partial;
  logic             win;

  mastermind_scorer #(
    .N_POS   (N_POS),
    .COLOR_W (COLOR_W),
    .N_COLORS(N_COLORS)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (start),
    .guess  (guess),
    .answer (answer),
    .busy   (busy),
    .done   (done),
    .exact  (exact),
    .partial(partial),
    .win    (win)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [CNT_W-1:0] e;
    logic [CNT_W-1:0] p;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] a;
    exp_t         x;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural Mastermind scoring: exact pegs first, then colour-multiset
  // overlap of the leftover pegs. Blank and out-of-range codes never score.
  function automatic exp_t ref_score(input logic [W-1:0] g, input logic [W-1:0] a);
    int   hg[N_COLORS];
    int   ha[N_COLORS];
    int   e;
    int   pt;
    exp_t r;
    e  = 0;
    pt = 0;
    for (int c = 0; c < N_COLORS; c++) begin
      hg[c] = 0;
      ha[c] = 0;
    end
    for (int p = 0; p < N_POS; p++) begin
      int gi;
      int ai;
      gi = int'(g[p*COLOR_W +: COLOR_W]);
      ai = int'(a[p*COLOR_W +: COLOR_W]);
      if (gi == ai && gi >= 1 && gi < N_COLORS) begin
        e++;
      end else begin
        if (gi >= 1 && gi < N_COLORS) hg[gi]++;
        if (ai >= 1 && ai < N_COLORS) ha[ai]++;
      end
    end
    for (int c = 1; c < N_COLORS; c++) pt += (hg[c] < ha[c]) ? hg[c] : ha[c];
    r.e = CNT_W'(e);
    r.p = CNT_W'(pt);
    return r;
  endfunction

  // Drive one start pulse across an edge and enqueue the expected result.
  // Returns at the falling edge just after the accepting edge.
  task automatic start_job(input logic [W-1:0] g, input logic [W-1:0] a, input exp_t x);
    @(negedge Clk);
    guess  = g;
    answer = a;
    start  = 1'b1;
    sb_q.push_back(x);
    @(negedge Clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  // Wait, bounded, for done; check its latency; then pop and compare.
  // lat0 is the number of edges already elapsed since the accepting edge.
  task automatic wait_done(input string name, input int lat0);
    int   lat;
    exp_t x;
    lat = lat0;
    while (!done && lat < 3 * LAT) begin
      @(negedge Clk);
      lat++;
    end
    if (!done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      check({name, "_latency"}, lat, LAT);
      check({name, "_busy_at_done"}, busy, 1'b0);
      if (sb_q.size() == 0) begin
        check({name, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
        x = sb_q.pop_front();
        check({name, "_exact"}, exact, x.e);
        check({name, "_partial"}, partial, x.p);
        check({name, "_win"}, win, (x.e == CNT_W'(N_POS)));
      end
    end
  endtask

  vec_t tbl[8];

  initial begin
    exp_t xa;
    exp_t xb;
    int   n_done;

    // Fixed vectors with hand-derived scores.
    tbl[0] = '{g: 12'b100_011_010_001, a: 12'b100_011_010_001, x: '{e: 3'd4, p: 3'd0}};
    tbl[1] = '{g: 12'b001_010_011_100, a: 12'b100_011_010_001, x: '{e: 3'd0, p: 3'd4}};
    tbl[2] = '{g: 12'b001_010_001_011, a: 12'b001_001_010_010, x: '{e: 3'd1, p: 3'd2}};
    tbl[3] = '{g: 12'b000_000_000_000, a: 12'b000_000_000_000, x: '{e: 3'd0, p: 3'd0}};
    tbl[4] = '{g: 12'b111_111_111_111, a: 12'b111_111_111_111, x: '{e: 3'd0, p: 3'd0}};
    tbl[5] = '{g: 12'b001_001_001_001, a: 12'b001_010_011_100, x: '{e: 3'd1, p: 3'd0}};
    tbl[6] = '{g: 12'b110_110_101_101, a: 12'b101_101_110_110, x: '{e: 3'd0, p: 3'd4}};
    tbl[7] = '{g: 12'b000_001_010_011, a: 12'b000_011_010_001, x: '{e: 3'd1, p: 3'd2}};

    // Reset state.
    Reset  = 1'b1;
    start  = 1'b0;
    guess  = '0;
    answer = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_exact", exact, 3'd0);
    check("rst_partial", partial, 3'd0);
    check("rst_win", win, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Table-driven scoring.
    for (int i = 0; i < 8; i++) begin
      start_job(tbl[i].g, tbl[i].a, tbl[i].x);
      wait_done($sformatf("vec%0d", i), 0);
    end

    // Random vectors against the reference scorer.
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] g;
      logic [W-1:0] a;
      g = W'($urandom);
      a = W'($urandom);
      if (i % 3 == 0) a = g ^ W'(1 << (COLOR_W * (i % N_POS)));
      start_job(g, a, ref_score(g, a));
      wait_done($sformatf("rnd%0d", i), 0);
    end

    // A start pulse at edge k+3 is ignored; the first job's results stand.
    start_job(tbl[0].g, tbl[0].a, tbl[0].x);
    @(negedge Clk);
    @(negedge Clk);
    guess  = tbl[1].g;
    answer = tbl[1].a;
    start  = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check("ignored_busy", busy, 1'b1);
    wait_done("ignored_start", 3);

    // Reset at edge k+5 aborts the run: outputs zero, no done pulse.
    start_job(tbl[2].g, tbl[2].a, tbl[2].x);
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_exact", exact, 3'd0);
    check("abort_partial", partial, 3'd0);
    check("abort_win", win, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    sb_q.delete();
    n_done = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge Clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Next start after reset is scored normally.
    start_job(tbl[5].g, tbl[5].a, tbl[5].x);
    wait_done("after_reset", 0);

    // Back-to-back: start held during the DONE cycle.
    xa = tbl[0].x;
    xb = tbl[2].x;
    start_job(tbl[0].g, tbl[0].a, xa);
    wait_done("b2b_first", 0);
    guess  = tbl[2].g;
    answer = tbl[2].a;
    start  = 1'b1;
    sb_q.push_back(xb);
    @(negedge Clk);
    start = 1'b0;
    check("b2b_busy_reassert", busy, 1'b1);
    check("b2b_done_low", done, 1'b0);
    check("b2b_exact_held", exact, xa.e);
    check("b2b_win_held", win, 1'b1);
    wait_done("b2b_second", 0);

    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
